// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game controller.
// Imported by the interface, the LFSR and the sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    PLAY_ON,
    PLAY_OFF,
    LISTEN,
    OVER,
    WIN
  } state_t;

  localparam int CODE_W = 2;

  // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/simon_if.sv
// Front-end to sequencer bundle: player inputs, playback and status.
// master = button/LED front end, slave = sequencer.
interface simon_if #(
  parameter int MAX_LEN = 16
);
  import simon_pkg::*;

  localparam int LW = $clog2(MAX_LEN + 1);

  logic              start;
  logic [CODE_W-1:0] playerNum;
  logic              playerPressed;
  logic              simonTurn;
  logic [CODE_W-1:0] simonNum;
  logic              simonPressed;
  logic [LW-1:0]     level;
  logic              gameOver;
  logic              gameWon;

  modport master (
    output start, playerNum, playerPressed,
    input  simonTurn, simonNum, simonPressed,
    input  level, gameOver, gameWon
  );

  modport slave (
    input  start, playerNum, playerPressed,
    output simonTurn, simonNum, simonPressed,
    output level, gameOver, gameWon
  );

endinterface

// File: rtl/simon_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; shifts every cycle out of reset.
// A non-zero seed keeps it on the maximal 255-state cycle.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/simon_sequencer.sv
// Simon game FSM: grows the sequence, plays it back, checks the
// player echo and reports level-up, win or game over.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter int         ON_CYCLES      = 4,
  parameter int         OFF_CYCLES     = 2,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic     clk,
  input  logic     rst_n,
  simon_if.slave   bus
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int TM1  = (ON_CYCLES > OFF_CYCLES) ?
                        ON_CYCLES : OFF_CYCLES;
  localparam int TMAX = (TM1 > TIMEOUT_CYCLES) ?
                        TM1 : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [LW-1:0] LAST_LEN = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE      = LW'(1);
  localparam logic [TW-1:0] ON_END   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_END  = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [LW-1:0]     len;
  logic [LW-1:0]     idx;
  logic [TW-1:0]     timer;
  logic [7:0]        lfsr;
  logic [CODE_W-1:0] mem [1 << LW];

  logic lastIdx;
  logic hit;
  logic playing;

  simon_lfsr #(.SEED(LFSR_SEED)) uLfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  assign lastIdx = (idx == len - ONE);
  assign hit     = (bus.playerNum == mem[idx]);
  assign playing = (state == PLAY_ON) || (state == PLAY_OFF);

  // Sequence RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == ADD) begin
      mem[len] <= lfsr[CODE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
      idx   <= '0;
      timer <= '0;
    end else begin
      unique case (state)
        IDLE, OVER, WIN: begin
          if (bus.start) begin
            state <= ADD;
            len   <= '0;
          end
        end
        ADD: begin
          len   <= len + ONE;
          idx   <= '0;
          timer <= '0;
          state <= PLAY_ON;
        end
        PLAY_ON: begin
          if (timer == ON_END) begin
            timer <= '0;
            state <= PLAY_OFF;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PLAY_OFF: begin
          if (timer == OFF_END) begin
            timer <= '0;
            if (lastIdx) begin
              idx   <= '0;
              state <= LISTEN;
            end else begin
              idx   <= idx + ONE;
              state <= PLAY_ON;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LISTEN: begin
          // a press on the timeout cycle wins over the timeout
          if (bus.playerPressed) begin
            if (!hit) begin
              state <= OVER;
            end else if (lastIdx) begin
              state <= (len == LAST_LEN) ? WIN : ADD;
            end else begin
              idx   <= idx + ONE;
              timer <= '0;
            end
          end else if (timer == TO_END) begin
            state <= OVER;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.simonTurn    = (state == ADD) || playing;
  assign bus.simonPressed = (state == PLAY_ON);
  assign bus.simonNum     = playing ? mem[idx] : '0;
  assign bus.level        = len;
  assign bus.gameOver     = (state == OVER);
  assign bus.gameWon      = (state == WIN);

endmodule

// File: tb/tb_simon_sequencer.sv
// Randomized bench for simon_sequencer against a queue-based
// model of the game rules and a mirrored LFSR.
module tb_simon_sequencer;
  import simon_pkg::*;

  localparam int         ML   = 3;
  localparam int         ON   = 2;
  localparam int         OFF  = 1;
  localparam int         TO   = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simon_if #(.MAX_LEN(ML)) bus ();

  simon_sequencer #(
    .MAX_LEN        (ML),
    .ON_CYCLES      (ON),
    .OFF_CYCLES     (OFF),
    .TIMEOUT_CYCLES (TO),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         nTests = 0;
  int         nFail  = 0;
  logic [7:0] mLfsr  = SEED;
  int         seq[$];

  task automatic check(input string tag, input int obs, input int exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // outputs packed as {turn, num[1:0], pressed, level[1:0], over, won}
  function automatic int pack(input bit t, input int n, input bit p,
                              input int l, input bit o, input bit w);
    logic [1:0] n2, l2;
    n2 = n[1:0];
    l2 = l[1:0];
    return int'({t, n2, p, l2, o, w});
  endfunction

  function automatic int seen();
    logic [7:0] v;
    v = {bus.simonTurn, bus.simonNum, bus.simonPressed,
         bus.level, bus.gameOver, bus.gameWon};
    return int'(v);
  endfunction

  task automatic expectOut(input string tag, input bit t, input int n,
                           input bit p, input int l, input bit o,
                           input bit w);
    check(tag, seen(), pack(t, n, p, l, o, w));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) mLfsr = step(mLfsr);
    #1;
  endtask

  task automatic startGame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seq.delete();
  endtask

  // entered during the ADD cycle, returns on the first LISTEN cycle
  task automatic playRound(input bit noise);
    int n;
    seq.push_back(int'(mLfsr[1:0]));
    n = seq.size();
    expectOut("add", 1, 0, 0, n - 1, 0, 0);
    tick();
    foreach (seq[i]) begin
      for (int c = 0; c < ON + OFF; c++) begin
        expectOut(c < ON ? "play_on" : "play_off",
                  1, seq[i], c < ON, n, 0, 0);
        if (noise) begin
          bus.playerPressed = 1'($urandom_range(0, 1));
          bus.playerNum     = 2'($urandom);
          bus.start         = 1'($urandom_range(0, 1));
        end
        tick();
      end
    end
    bus.playerPressed = 1'b0;
    bus.start = 1'b0;
    expectOut("listen", 0, 0, 0, n, 0, 0);
  endtask

  // gap < 0 picks a random idle gap before each press
  task automatic echo(input int wrongAt, input int gap);
    int g, n;
    n = seq.size();
    foreach (seq[i]) begin
      g = (gap >= 0) ? gap : int'($urandom_range(0, TO - 1));
      for (int k = 0; k < g; k++) begin
        expectOut("wait", 0, 0, 0, n, 0, 0);
        bus.start = ($urandom_range(0, 3) == 0);
        tick();
        bus.start = 1'b0;
      end
      bus.playerPressed = 1'b1;
      bus.playerNum = (i == wrongAt) ?
        2'(seq[i] ^ int'($urandom_range(1, 3))) : 2'(seq[i]);
      tick();
      bus.playerPressed = 1'b0;
      if (i == wrongAt) begin
        expectOut("wrong_over", 0, 0, 0, n, 1, 0);
        return;
      end
    end
  endtask

  task automatic game(input int failRound, input int failIdx,
                      input bit noise);
    startGame();
    for (int r = 1; r <= ML; r++) begin
      playRound(noise);
      if (r == failRound) begin
        echo(failIdx, -1);
        tick();
        expectOut("over_sticky", 0, 0, 0, r, 1, 0);
        return;
      end
      echo(-1, -1);
    end
    expectOut("win", 0, 0, 0, ML, 0, 1);
    tick();
    expectOut("win_sticky", 0, 0, 0, ML, 0, 1);
  endtask

  initial begin
    int fr;
    bus.start = 1'b0;
    bus.playerNum = '0;
    bus.playerPressed = 1'b0;
    tick();
    tick();
    expectOut("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // full winning game, then a loss in round 2 at index 0
    game(0, 0, 1'b0);
    game(2, 0, 1'b0);

    // timeout: TO idle listen cycles end the game
    startGame();
    playRound(1'b0);
    for (int k = 0; k < TO; k++) begin
      expectOut("no_timeout_yet", 0, 0, 0, 1, 0, 0);
      tick();
    end
    expectOut("timeout", 0, 0, 0, 1, 1, 0);

    // press on the last allowed cycle beats the timeout
    startGame();
    for (int r = 1; r <= ML; r++) begin
      playRound(1'b0);
      echo(-1, TO - 1);
    end
    expectOut("late_win", 0, 0, 0, ML, 0, 1);

    // presses and starts during playback are ignored
    game(0, 0, 1'b1);

    // asynchronous reset in the middle of PLAY_ON
    startGame();
    playRound(1'b0);
    echo(-1, 0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    expectOut("async_reset", 0, 0, 0, 0, 0, 0);
    mLfsr = SEED;
    tick();
    tick();
    rst_n = 1'b1;
    game(0, 0, 1'b0);

    for (int g = 0; g < 25; g++) begin
      for (int k = $urandom_range(0, 5); k > 0; k--) tick();
      fr = $urandom_range(0, ML);
      game(fr, (fr > 0) ? int'($urandom_range(0, fr - 1)) : 0,
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
